otter_bus_router: RTL and testbench

- Single-master, N-slave router for the OTTER system bus.
- Sits between the core's bus port and the memory/peripheral slaves: SRAM, MMIO, and future devices.
- Decodes each request address against per-slave base/mask windows and forwards the request to exactly one slave.
- Tracks the single outstanding transaction, routes the response back, and returns a bus error on decode miss or, optionally, on timeout.

---
 rtl/otter_bus_pkg.sv | 40 ++++
 rtl/otter_addr_decode.sv | 43 ++++
 rtl/otter_bus_router.sv | 194 +++++++++++++++++++
 tb/tb_otter_bus_router.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_bus_pkg.sv
// ---------------------------------------------------------------------------
// otter_bus_pkg
// Shared types and constants for the OTTER system bus router.
//   router_state_t       : router FSM states
//   OTTER_SLV_BASE_DEF   : default slave base addresses (slave i in slice i)
//   OTTER_SLV_MASK_DEF   : default slave address masks  (slave i in slice i)
//   otter_idx_w()        : slave index width, $clog2(n) with a minimum of 1
//   slv_idx_t            : slave index type for the default 4-slave map
// ---------------------------------------------------------------------------
package otter_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } router_state_t;

  localparam int unsigned OTTER_NUM_SLAVES_DEF = 4;

  // Slice 0 (least significant) belongs to slave 0:
  //   0: SRAM   0x0000_0000 / 64 KiB
  //   1: SRAM   0x0001_0000 / 64 KiB
  //   2: MMIO   0x1100_0000 /  4 KiB
  //   3: MMIO   0x1200_0000 /  4 KiB
  localparam logic [4*32-1:0] OTTER_SLV_BASE_DEF = {
    32'h1200_0000, 32'h1100_0000, 32'h0001_0000, 32'h0000_0000
  };
  localparam logic [4*32-1:0] OTTER_SLV_MASK_DEF = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000
  };

  function automatic int unsigned otter_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [otter_idx_w(OTTER_NUM_SLAVES_DEF)-1:0] slv_idx_t;

endpackage

// File: rtl/otter_addr_decode.sv
// ---------------------------------------------------------------------------
// otter_addr_decode
// Combinational priority address decoder. Slave i matches when
// (addr & mask_i) == base_i; if several windows match, the lowest index wins.
//   addr_i : request address
//   hit_o  : at least one window matched
//   idx_o  : index of the lowest matching slave (0 when no hit)
// ---------------------------------------------------------------------------
module otter_addr_decode
  import otter_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = OTTER_SLV_BASE_DEF,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = OTTER_SLV_MASK_DEF,
  parameter int unsigned IDX_W      = otter_idx_w(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic [NUM_SLAVES-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_win
      assign match[gi] =
        ((addr_i & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  assign hit_o = |match;

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/otter_bus_router.sv
// ---------------------------------------------------------------------------
// otter_bus_router
// Single-master, N-slave router for the OTTER system bus. One transaction
// may be outstanding. The request is registered on acceptance, forwarded to
// exactly one slave selected by base/mask decode, and the slave response is
// returned on a one-cycle m_rvalid strobe. Decode misses return m_err.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m_req/m_ready              master request handshake
//   m_addr/m_we/m_wdata/m_be   master request fields
//   m_rvalid/m_rdata/m_err     master response (rdata is 0 on writes/errors)
//   s_req                      one-hot slave request
//   s_addr/s_we/s_wdata/s_be   registered request, shared by all slaves
//   s_ready/s_rvalid/s_err     per-slave handshake and response flags
//   s_rdata                    per-slave read data, slave i in slice i
//
// Build option: define OTTER_ROUTER_TIMEOUT_EN to return an error once a
// slave has not responded within TIMEOUT_CYC cycles of entering REQ.
// Limitation: a stale response arriving during a later transaction to the
// same slave cannot be told apart from the real one.
// ---------------------------------------------------------------------------
module otter_bus_router
  import otter_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = OTTER_SLV_BASE_DEF,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = OTTER_SLV_MASK_DEF,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  // master side
  input  logic                         m_req,
  output logic                         m_ready,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic                         m_we,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_be,
  output logic                         m_rvalid,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  // slave side
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic [ADDR_W-1:0]            s_addr,
  output logic                         s_we,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_be,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES-1:0]        s_rvalid,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_err
);

  localparam int unsigned IDX_W = otter_idx_w(NUM_SLAVES);

  router_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [IDX_W-1:0]    sel_q;
  logic                hit_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                accept;
  logic                capture;
  logic                req_active;
  logic                timeout_hit;

  otter_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr_i (m_addr),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign accept = (state_q == IDLE) && m_req;

  // The decode result is registered with the request and acted on in REQ:
  // a miss leaves REQ straight for ERR without ever raising s_req, which
  // puts the error strobe two cycles after acceptance.
  assign req_active = (state_q == REQ) && hit_q;

  // Response capture also covers s_rvalid arriving together with s_ready.
  assign capture = s_rvalid[sel_q] &&
                   ((req_active && s_ready[sel_q]) || (state_q == RESP));

`ifdef OTTER_ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == REQ) || (state_q == RESP)) begin
      cnt_q <= cnt_inc;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m_req) state_d = REQ;
      end
      REQ: begin
        if (!hit_q) begin
          state_d = ERR;
        end else if (s_ready[sel_q]) begin
          state_d = s_rvalid[sel_q] ? DONE : RESP;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      RESP: begin
        if (s_rvalid[sel_q]) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= m_addr;
        we_q    <= m_we;
        wdata_q <= m_wdata;
        be_q    <= m_be;
        sel_q   <= dec_idx;
        hit_q   <= dec_hit;
      end
      if (capture) begin
        rdata_q <= s_rdata[sel_q*DATA_W +: DATA_W];
        err_q   <= s_err[sel_q];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sreq
      assign s_req[gi] = req_active && (sel_q == IDX_W'(gi));
    end
  endgenerate

  assign s_addr  = addr_q;
  assign s_we    = we_q;
  assign s_wdata = wdata_q;
  assign s_be    = be_q;

  assign m_ready  = (state_q == IDLE);
  assign m_rvalid = (state_q == DONE) || (state_q == ERR);
  assign m_err    = (state_q == ERR) || ((state_q == DONE) && err_q);
  assign m_rdata  = ((state_q == DONE) && !we_q && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_otter_bus_router.sv
// ---------------------------------------------------------------------------
// tb_otter_bus_router
// Directed-vector bench for otter_bus_router with hand-computed expectations.
// Cycle 0 is the cycle in which m_req is sampled; inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// Define OTTER_ROUTER_TIMEOUT_EN to also exercise the timeout path
// (TIMEOUT_CYC is overridden to 8).
// ---------------------------------------------------------------------------
module tb_otter_bus_router;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_req;
  logic            m_ready;
  logic [AW-1:0]   m_addr;
  logic            m_we;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_be;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic [NS-1:0]   s_req;
  logic [AW-1:0]   s_addr;
  logic            s_we;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_be;
  logic [NS-1:0]   s_ready;
  logic [NS-1:0]   s_rvalid;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]   s_err;

  int n_tests = 0;
  int n_fail  = 0;

  otter_bus_router #(
    .TIMEOUT_CYC (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_we     (s_we),
    .s_wdata  (s_wdata),
    .s_be     (s_be),
    .s_ready  (s_ready),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata),
    .s_err    (s_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_slaves();
    s_ready  = '0;
    s_rvalid = '0;
    s_err    = '0;
  endtask

  // Zero-wait read; slave 3 raises a spurious erroring strobe alongside the
  // real response, which must be ignored (sel must not be 3).
  task automatic rd_zero_wait(input string nm, input logic [31:0] addr,
                              input logic [3:0] exp_req, input int sel,
                              input logic [31:0] data);
    m_req = 1'b1; m_addr = addr; m_we = 1'b0; m_be = 4'hF; m_wdata = '0;
    check_eq({nm, " c0 m_ready"}, 64'(m_ready), 64'd1);
    step();
    m_req = 1'b0;
    check_eq({nm, " c1 s_req"}, 64'(s_req), 64'(exp_req));
    check_eq({nm, " c1 s_addr"}, 64'(s_addr), 64'(addr));
    s_ready = exp_req;
    step();
    s_ready  = '0;
    s_rvalid = exp_req | 4'b1000;
    s_err    = 4'b1000;
    s_rdata[sel*DW +: DW] = data;
    s_rdata[3*DW +: DW]   = 32'h3333_3333;
    check_eq({nm, " c2 m_rvalid"}, 64'(m_rvalid), 64'd0);
    step();
    quiet_slaves();
    check_eq({nm, " c3 m_rvalid"}, 64'(m_rvalid), 64'd1);
    check_eq({nm, " c3 m_rdata"}, 64'(m_rdata), 64'(data));
    check_eq({nm, " c3 m_err"}, 64'(m_err), 64'd0);
    step();
    check_eq({nm, " c4 m_ready"}, 64'(m_ready), 64'd1);
    check_eq({nm, " c4 m_rvalid"}, 64'(m_rvalid), 64'd0);
    $display("[TB] txn %s read addr=0x%08h data=0x%08h", nm, addr, data);
  endtask

  task automatic miss(input string nm, input logic [31:0] addr);
    m_req = 1'b1; m_addr = addr; m_we = 1'b0; m_be = 4'hF;
    step();
    m_req = 1'b0;
    check_eq({nm, " c1 s_req"}, 64'(s_req), 64'd0);
    check_eq({nm, " c1 m_rvalid"}, 64'(m_rvalid), 64'd0);
    step();
    check_eq({nm, " c2 s_req"}, 64'(s_req), 64'd0);
    check_eq({nm, " c2 m_rvalid"}, 64'(m_rvalid), 64'd1);
    check_eq({nm, " c2 m_err"}, 64'(m_err), 64'd1);
    check_eq({nm, " c2 m_rdata"}, 64'(m_rdata), 64'd0);
    step();
    check_eq({nm, " c3 m_ready"}, 64'(m_ready), 64'd1);
    check_eq({nm, " c3 m_rvalid"}, 64'(m_rvalid), 64'd0);
    $display("[TB] txn %s miss addr=0x%08h", nm, addr);
  endtask

  initial begin
    rst = 1'b1;
    m_req = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_be = '0;
    s_rdata = '0;
    quiet_slaves();
    step();
    step();
    // reset state
    check_eq("rst m_ready", 64'(m_ready), 64'd1);
    check_eq("rst s_req", 64'(s_req), 64'd0);
    check_eq("rst m_rvalid", 64'(m_rvalid), 64'd0);
    check_eq("rst m_err", 64'(m_err), 64'd0);
    check_eq("rst m_rdata", 64'(m_rdata), 64'd0);
    check_eq("rst s_addr", 64'(s_addr), 64'd0);
    check_eq("rst s_wdata", 64'(s_wdata), 64'd0);
    check_eq("rst s_be", 64'(s_be), 64'd0);
    check_eq("rst s_we", 64'(s_we), 64'd0);
    rst = 1'b0;
    step();

    // 1: zero-wait read of slave 0
    rd_zero_wait("rd_s0", 32'h0000_0010, 4'b0001, 0, 32'hDEAD_BEEF);

    // 2: write to slave 2 with s_ready low for 5 cycles
    m_req = 1'b1; m_addr = 32'h1100_0004; m_we = 1'b1; m_wdata = 32'hCAFE_1234; m_be = 4'b0011;
    step();
    m_req = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_we = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check_eq($sformatf("wr c%0d s_req", c), 64'(s_req), 64'b0100);
      check_eq($sformatf("wr c%0d s_addr", c), 64'(s_addr), 64'h1100_0004);
      check_eq($sformatf("wr c%0d s_wdata", c), 64'(s_wdata), 64'hCAFE_1234);
      check_eq($sformatf("wr c%0d s_be", c), 64'(s_be), 64'b0011);
      check_eq($sformatf("wr c%0d s_we", c), 64'(s_we), 64'd1);
      check_eq($sformatf("wr c%0d m_rvalid", c), 64'(m_rvalid), 64'd0);
      if (c == 6) begin
        // accept and respond in the same cycle; read data must not leak
        s_ready  = 4'b0100;
        s_rvalid = 4'b0100;
        s_rdata[2*DW +: DW] = 32'hFFFF_FFFF;
      end
      step();
    end
    quiet_slaves();
    check_eq("wr c7 m_rvalid", 64'(m_rvalid), 64'd1);
    check_eq("wr c7 m_rdata", 64'(m_rdata), 64'd0);
    check_eq("wr c7 m_err", 64'(m_err), 64'd0);
    step();
    check_eq("wr c8 m_rvalid", 64'(m_rvalid), 64'd0);
    check_eq("wr c8 m_ready", 64'(m_ready), 64'd1);
    $display("[TB] txn wr_s2 write addr=0x11000004 data=0xcafe1234 be=0x3");

    // 3: decode misses, including the first address past slave 2's window
    miss("miss_far", 32'h2000_0000);
    miss("miss_edge", 32'h1100_1000);

    // 4: top of slave 2's window, response together with s_ready
    m_req = 1'b1; m_addr = 32'h1100_0FFC; m_we = 1'b0; m_be = 4'hF;
    step();
    m_req = 1'b0;
    check_eq("edge c1 s_req", 64'(s_req), 64'b0100);
    s_ready = 4'b0100; s_rvalid = 4'b0100; s_rdata[2*DW +: DW] = 32'h0BAD_F00D;
    step();
    quiet_slaves();
    check_eq("edge c2 m_rvalid", 64'(m_rvalid), 64'd1);
    check_eq("edge c2 m_rdata", 64'(m_rdata), 64'h0BAD_F00D);
    step();
    check_eq("edge c3 m_ready", 64'(m_ready), 64'd1);
    $display("[TB] txn edge_s2 read addr=0x11000ffc data=0x0badf00d");

    // 5: slave 1 error response; slave 3 spurious strobes ignored
    m_req = 1'b1; m_addr = 32'h0001_0020; m_we = 1'b0; m_be = 4'hF;
    step();
    m_req = 1'b0;
    check_eq("err c1 s_req", 64'(s_req), 64'b0010);
    s_ready = 4'b0010;
    step();
    s_ready = '0; s_rvalid = 4'b1000; s_err = 4'b1000; s_rdata[3*DW +: DW] = 32'h3333_3333;
    step();
    check_eq("err c3 m_rvalid", 64'(m_rvalid), 64'd0);
    s_rvalid = 4'b1010; s_err = 4'b0010; s_rdata[1*DW +: DW] = 32'h1111_1111;
    step();
    quiet_slaves();
    check_eq("err c4 m_rvalid", 64'(m_rvalid), 64'd1);
    check_eq("err c4 m_err", 64'(m_err), 64'd1);
    check_eq("err c4 m_rdata", 64'(m_rdata), 64'd0);
    step();
    check_eq("err c5 m_ready", 64'(m_ready), 64'd1);
    $display("[TB] txn err_s1 read addr=0x00010020 slave error");

    // 6: reset while in RESP
    m_req = 1'b1; m_addr = 32'h0000_0040; m_we = 1'b0; m_be = 4'hF;
    step();
    m_req = 1'b0;
    s_ready = 4'b0001;
    step();
    s_ready = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstx s_req", 64'(s_req), 64'd0);
    check_eq("rstx m_ready", 64'(m_ready), 64'd1);
    check_eq("rstx m_rvalid", 64'(m_rvalid), 64'd0);
    s_rvalid = 4'b0001; s_rdata[0*DW +: DW] = 32'h5555_5555;
    step();
    quiet_slaves();
    check_eq("rstx late m_rvalid", 64'(m_rvalid), 64'd0);
    step();
    check_eq("rstx idle m_rvalid", 64'(m_rvalid), 64'd0);
    $display("[TB] txn rst_in_resp dropped addr=0x00000040");

`ifdef OTTER_ROUTER_TIMEOUT_EN
    // 7: slave 2 never responds; error 8 cycles after entering REQ
    m_req = 1'b1; m_addr = 32'h1100_0000; m_we = 1'b0; m_be = 4'hF;
    step();
    m_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check_eq($sformatf("to c%0d s_req", c), 64'(s_req), 64'b0100);
      check_eq($sformatf("to c%0d m_rvalid", c), 64'(m_rvalid), 64'd0);
      step();
    end
    check_eq("to c9 m_rvalid", 64'(m_rvalid), 64'd1);
    check_eq("to c9 m_err", 64'(m_err), 64'd1);
    check_eq("to c9 s_req", 64'(s_req), 64'd0);
    s_rvalid = 4'b0100;
    step();
    quiet_slaves();
    check_eq("to c10 m_rvalid", 64'(m_rvalid), 64'd0);
    check_eq("to c10 m_ready", 64'(m_ready), 64'd1);
    $display("[TB] txn timeout_s2 read addr=0x11000000 timed out");
    rd_zero_wait("after_to", 32'h0000_0100, 4'b0001, 0, 32'h1234_5678);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
